// File: rtl/kbd_text_writer_if.sv
// Keyboard text writer bus.
// Carries the receiver-side inputs (rx_done_tick, scan_code, ascii_in) and
// the character-buffer write port plus status outputs (we, waddr, wdata,
// cursor, busy, char_tick).
//   master : keyboard receiver / buffer side (drives rx_done_tick, scan_code, ascii_in)
//   slave  : the text writer (drives the write port and status)
interface kbd_text_writer_if #(
  parameter int ADDR_W = 6
);
  logic              rx_done_tick;
  logic [7:0]        scan_code;
  logic [7:0]        ascii_in;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;
  logic [ADDR_W-1:0] cursor;
  logic              busy;
  logic              char_tick;

  modport master (
    output rx_done_tick, scan_code, ascii_in,
    input  we, waddr, wdata, cursor, busy, char_tick
  );

  modport slave (
    input  rx_done_tick, scan_code, ascii_in,
    output we, waddr, wdata, cursor, busy, char_tick
  );
endinterface

// File: rtl/kbd_text_writer.sv
// Keyboard text writer: turns PS/2 set-2 scan codes into writes to a
// character buffer of 2^ADDR_W cells. Out of reset it sweeps the whole buffer
// with BLANK (busy=1), then writes printable characters at the cursor,
// handles backspace and enter, and swallows break (F0) / extended (E0)
// sequences.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : kbd_text_writer_if.slave
//           in  rx_done_tick, scan_code, ascii_in
//           out we, waddr, wdata, cursor, busy, char_tick (all registered)
// Build option:
//   KBD_TEXT_SHIFT_EN : track shift make/break and upper-case a..z while
//                       shift is held. Without it shift codes are consumed
//                       silently and wdata is ascii_in.
module kbd_text_writer #(
  parameter int         ADDR_W  = 6,
  parameter int         ROW_LEN = 16,
  parameter logic [7:0] BLANK   = 8'h20
) (
  input logic            clk,
  input logic            reset,
  kbd_text_writer_if.slave bus
);

  typedef enum logic [1:0] {CLEAR, IDLE, BREAK, EXT} state_t;

  localparam logic [ADDR_W-1:0] LAST     = '1;
  localparam logic [ADDR_W-1:0] ROW_MASK = ADDR_W'(ROW_LEN - 1);

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_LSHFT = 8'h12;
  localparam logic [7:0] SC_RSHFT = 8'h59;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  state_t            state, state_n;
  logic [ADDR_W-1:0] sweep, sweep_n;
  logic [ADDR_W-1:0] cursor, cursor_n;
  logic [ADDR_W-1:0] waddr, waddr_n;
  logic [7:0]        wdata, wdata_n;
  logic              we, we_n;
  logic              char_tick, char_tick_n;
  logic              busy, busy_n;
  logic [7:0]        char_out;
  logic              is_shift;

`ifdef KBD_TEXT_SHIFT_EN
  logic shift, shift_n;
`endif

  assign is_shift = (bus.scan_code == SC_LSHFT) || (bus.scan_code == SC_RSHFT);

`ifdef KBD_TEXT_SHIFT_EN
  always_comb begin
    char_out = bus.ascii_in;
    if (shift && bus.ascii_in >= 8'h61 && bus.ascii_in <= 8'h7A)
      char_out = bus.ascii_in - 8'h20;
  end
`else
  assign char_out = bus.ascii_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      sweep     <= '0;
      cursor    <= '0;
      waddr     <= '0;
      wdata     <= '0;
      we        <= 1'b0;
      char_tick <= 1'b0;
      busy      <= 1'b1;
`ifdef KBD_TEXT_SHIFT_EN
      shift     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      sweep     <= sweep_n;
      cursor    <= cursor_n;
      waddr     <= waddr_n;
      wdata     <= wdata_n;
      we        <= we_n;
      char_tick <= char_tick_n;
      busy      <= busy_n;
`ifdef KBD_TEXT_SHIFT_EN
      shift     <= shift_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    sweep_n     = sweep;
    cursor_n    = cursor;
    waddr_n     = waddr;
    wdata_n     = wdata;
    we_n        = 1'b0;
    char_tick_n = 1'b0;
    // busy trails the state by one cycle so it stays high alongside the
    // last sweep write (addr LAST) and drops with we.
    busy_n      = (state == CLEAR);
`ifdef KBD_TEXT_SHIFT_EN
    shift_n     = shift;
`endif

    unique case (state)
      CLEAR: begin
        // Ticks arriving here are dropped on purpose.
        we_n    = 1'b1;
        waddr_n = sweep;
        wdata_n = BLANK;
        sweep_n = sweep + 1'b1;
        if (sweep == LAST) state_n = IDLE;
      end

      IDLE: if (bus.rx_done_tick) begin
        if (bus.scan_code == SC_BREAK) begin
          state_n = BREAK;
        end else if (bus.scan_code == SC_EXT) begin
          state_n = EXT;
        end else if (is_shift) begin
`ifdef KBD_TEXT_SHIFT_EN
          shift_n = 1'b1;
`endif
        end else if (bus.scan_code == SC_BKSP) begin
          if (cursor != '0) begin
            we_n     = 1'b1;
            waddr_n  = cursor - 1'b1;
            wdata_n  = BLANK;
            cursor_n = cursor - 1'b1;
          end
        end else if (bus.scan_code == SC_ENTER) begin
          // Round up to the next row start; wraps to 0 from the last row.
          cursor_n = (cursor | ROW_MASK) + 1'b1;
        end else if (bus.ascii_in != 8'h00) begin
          we_n        = 1'b1;
          char_tick_n = 1'b1;
          waddr_n     = cursor;
          wdata_n     = char_out;
          cursor_n    = cursor + 1'b1;
        end
      end

      BREAK: if (bus.rx_done_tick) begin
        state_n = IDLE;
`ifdef KBD_TEXT_SHIFT_EN
        if (is_shift) shift_n = 1'b0;
`endif
      end

      EXT: if (bus.rx_done_tick) begin
        state_n = (bus.scan_code == SC_BREAK) ? BREAK : IDLE;
      end

      default: state_n = CLEAR;
    endcase
  end

  assign bus.we        = we;
  assign bus.waddr     = waddr;
  assign bus.wdata     = wdata;
  assign bus.cursor    = cursor;
  assign bus.busy      = busy;
  assign bus.char_tick = char_tick;

endmodule

// File: tb/tb_kbd_text_writer.sv
// Directed bench for kbd_text_writer: clear sweep, printable/break/extended
// handling, shift (either build), backspace/enter boundaries, tick dropped
// during the sweep and reset aborting a sweep.
module tb_kbd_text_writer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errs = 0;
  int   checks = 0;

  kbd_text_writer_if #(.ADDR_W(6)) bus ();

  kbd_text_writer #(.ADDR_W(6), .ROW_LEN(16), .BLANK(8'h20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef KBD_TEXT_SHIFT_EN
  localparam logic [7:0] SHIFT_A = 8'h41;
`else
  localparam logic [7:0] SHIFT_A = 8'h61;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle tick; returns at the negedge after the accepting posedge.
  task automatic send(input logic [7:0] code, input logic [7:0] ascii);
    bus.rx_done_tick = 1'b1;
    bus.scan_code    = code;
    bus.ascii_in     = ascii;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    bus.scan_code    = 8'h00;
    bus.ascii_in     = 8'h00;
  endtask

  // Expect no write from the last tick.
  task automatic no_write(input string tag, input int cur);
    chk({tag, ".we"}, 32'(bus.we), 0);
    chk({tag, ".tick"}, 32'(bus.char_tick), 0);
    chk({tag, ".cursor"}, 32'(bus.cursor), 32'(cur));
  endtask

  task automatic wrote(input string tag, input int addr, input logic [7:0] data,
                       input bit ct, input int cur);
    chk({tag, ".we"}, 32'(bus.we), 1);
    chk({tag, ".waddr"}, 32'(bus.waddr), 32'(addr));
    chk({tag, ".wdata"}, 32'(bus.wdata), 32'(data));
    chk({tag, ".tick"}, 32'(bus.char_tick), 32'(ct));
    chk({tag, ".cursor"}, 32'(bus.cursor), 32'(cur));
  endtask

  // Called one negedge after reset release: checks 64 sweep writes, with an
  // optional tick injected during sweep cycle inject_at (-1 for none).
  task automatic sweep_chk(input string tag, input int inject_at);
    int ticks = 0;
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (bus.we !== 1'b1 || bus.waddr !== 6'(i) || bus.wdata !== 8'h20 || bus.busy !== 1'b1)
        bad++;
      if (bus.char_tick === 1'b1) ticks++;
      if (i == inject_at) begin
        bus.rx_done_tick = 1'b1; bus.scan_code = 8'h1C; bus.ascii_in = 8'h61;
      end
      @(negedge clk);
      bus.rx_done_tick = 1'b0; bus.scan_code = 8'h00; bus.ascii_in = 8'h00;
    end
    chk({tag, ".sweep_bad"}, 32'(bad), 0);
    chk({tag, ".sweep_ticks"}, 32'(ticks), 0);
    chk({tag, ".busy_done"}, 32'(bus.busy), 0);
    chk({tag, ".we_done"}, 32'(bus.we), 0);
    chk({tag, ".cursor_done"}, 32'(bus.cursor), 0);
  endtask

  initial begin
    bus.rx_done_tick = 1'b0;
    bus.scan_code    = 8'h00;
    bus.ascii_in     = 8'h00;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst.we", 32'(bus.we), 0);
    chk("rst.busy", 32'(bus.busy), 1);
    chk("rst.waddr", 32'(bus.waddr), 0);
    chk("rst.wdata", 32'(bus.wdata), 0);
    chk("rst.cursor", 32'(bus.cursor), 0);
    chk("rst.tick", 32'(bus.char_tick), 0);

    reset = 1'b0;
    @(negedge clk);
    sweep_chk("clr0", -1);

    // Make, break, make: a single write
    send(8'h1C, 8'h61); wrote("a", 0, 8'h61, 1, 1);
    @(negedge clk);     no_write("a_pulse", 1);
    send(8'hF0, 8'h00); no_write("brk", 1);
    send(8'h1C, 8'h61); no_write("brk_code", 1);

    // Shift held, then released
    send(8'h12, 8'h00); no_write("shmake", 1);
    send(8'h1C, 8'h61); wrote("shA", 1, SHIFT_A, 1, 2);
    send(8'hF0, 8'h00); no_write("shbrk0", 2);
    send(8'h12, 8'h00); no_write("shbrk1", 2);
    send(8'h1C, 8'h61); wrote("a2", 2, 8'h61, 1, 3);

    // Backspace at cursor 3
    send(8'h66, 8'h00); wrote("bksp", 2, 8'h20, 0, 2);

    // Non-printable and extended sequences write nothing
    send(8'h05, 8'h00); no_write("nonprint", 2);
    send(8'hE0, 8'h00); no_write("ext0", 2);
    send(8'h1C, 8'h61); no_write("ext1", 2);
    send(8'hE0, 8'h00); send(8'hF0, 8'h00); send(8'h1C, 8'h61);
    no_write("extbrk", 2);

    // Bring cursor to 5, enter -> 16, 32, 48
    for (int i = 0; i < 3; i++) send(8'h1C, 8'h61);
    chk("cur5", 32'(bus.cursor), 5);
    send(8'h5A, 8'h00); no_write("enter5", 16);
    send(8'h5A, 8'h00); no_write("enter16", 32);
    send(8'h5A, 8'h00); no_write("enter32", 48);

    // Fill to 63, write at 63 wraps cursor to 0
    for (int i = 0; i < 15; i++) send(8'h1C, 8'h61);
    chk("cur63", 32'(bus.cursor), 63);
    send(8'h32, 8'h62); wrote("wrap", 63, 8'h62, 1, 0);
    send(8'h66, 8'h00); no_write("bksp0", 0);

    // Enter from the last row wraps to 0
    send(8'h5A, 8'h00); send(8'h5A, 8'h00); send(8'h5A, 8'h00);
    chk("cur48b", 32'(bus.cursor), 48);
    for (int i = 0; i < 2; i++) send(8'h1C, 8'h61);
    send(8'h5A, 8'h00); no_write("enter50", 0);

    // Reset mid-sequence (shift + break pending) then mid-sweep
    send(8'h12, 8'h00); send(8'hF0, 8'h00);
    reset = 1'b1; #1;
    chk("rst2.busy", 32'(bus.busy), 1);
    chk("rst2.cursor", 32'(bus.cursor), 0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge clk);
    chk("mid.waddr", 32'(bus.waddr), 19);
    reset = 1'b1; #1;
    chk("rst3.we", 32'(bus.we), 0);
    chk("rst3.waddr", 32'(bus.waddr), 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    sweep_chk("clr1", 10);

    // Shift was cleared by reset: plain lowercase
    send(8'h1C, 8'h61); wrote("post", 0, 8'h61, 1, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
